// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
// Per-player kinematics stage, one instance per player. Turns the raw move and
// jump controls into the sprite top-left position and the smash flag used by
// the ball-physics block. A point-scored pulse (round_rst) from that block puts
// the player back at the serve position and freezes input for a while.
// All motion advances only on frame_tick.
//
// Vertical position is kept as 16-bit signed with 6 fractional bits (y_q).
// Vertical velocity is 11-bit signed in 1/64 px per frame.
//
// Optional build macro: PLAYER_AIR_LOCK_EN
//   defined   - horizontal direction is latched at take-off and replayed on
//               every airborne tick; live move keys are ignored in the air.
//   undefined - move keys act live in every state except FROZEN.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   frame_tick    in   one-clk frame strobe
//   op_move_left  in   level, move left
//   op_move_right in   level, move right
//   op_jump       in   level, jump / smash key
//   round_rst     in   one-clk point-scored pulse, any cycle
//   pos_x         out  [9:0] sprite left x, pixels
//   pos_y         out  [9:0] sprite top y, pixels
//   is_smash      out  smash window active
//   airborne      out  high while in the air (AIR or SMASH)
// -----------------------------------------------------------------------------
module player_motion #(
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 90,
    parameter int HOME_X        = 36,
    parameter int FLOOR_Y       = 176,
    parameter int MOVE_SPEED    = 3,
    parameter int JUMP_VEL      = -512,
    parameter int GRAVITY       = 24,
    parameter int SMASH_LEN     = 8,
    parameter int FREEZE_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       op_move_left,
    input  logic       op_move_right,
    input  logic       op_jump,
    input  logic       round_rst,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       is_smash,
    output logic       airborne
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_AIR    = 2'd1,
        ST_SMASH  = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    localparam logic signed [11:0] X_MIN_S  = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
    localparam logic signed [11:0] SPEED_S  = 12'(MOVE_SPEED);
    localparam logic        [9:0]  X_MIN_U  = 10'(X_MIN);
    localparam logic        [9:0]  X_MAX_U  = 10'(X_MAX);
    localparam logic        [9:0]  HOME_U   = 10'(HOME_X);
    localparam logic signed [15:0] FLOOR_Q  = 16'(FLOOR_Y * 64);
    localparam logic signed [10:0] JUMP_V   = 11'(JUMP_VEL);
    localparam logic signed [10:0] GRAV_V   = 11'(GRAVITY);
    localparam logic        [7:0]  SMASH_C  = 8'(SMASH_LEN);
    localparam logic        [7:0]  FREEZE_C = 8'(FREEZE_FRAMES);

    state_t             state_r, state_s;
    logic        [9:0]  x_r, x_s;
    logic signed [15:0] y_q_r, y_q_s;
    logic signed [10:0] vel_r, vel_s;
    logic        [7:0]  smash_cnt_r, smash_cnt_s;
    logic        [7:0]  frz_cnt_r, frz_cnt_s;
    logic               jump_prev_r, jump_prev_s;
    logic               is_smash_r, airborne_r;

    logic signed [1:0]  live_dir_s, dir_use_s;
    logic signed [11:0] x_ext_s, x_step_s;
    logic        [9:0]  x_sat_s;
    logic signed [10:0] vel_air_s;
    logic signed [15:0] y_air_s, y_jump_s;
    logic               jump_edge_s;
`ifdef PLAYER_AIR_LOCK_EN
    logic signed [1:0]  dir_r, dir_s;
`endif

    // Candidate horizontal/vertical updates shared by all moving states
    always_comb begin
        live_dir_s = 2'sb00;
        if (op_move_left && !op_move_right) begin
            live_dir_s = 2'sb11;
        end else if (op_move_right && !op_move_left) begin
            live_dir_s = 2'sb01;
        end else begin
            live_dir_s = 2'sb00;
        end

`ifdef PLAYER_AIR_LOCK_EN
        if ((state_r == ST_AIR) || (state_r == ST_SMASH)) begin
            dir_use_s = dir_r;
        end else begin
            dir_use_s = live_dir_s;
        end
`else
        dir_use_s = live_dir_s;
`endif

        // 12-bit signed so a step below X_MIN is seen as negative, not wrapped
        x_ext_s = signed'({2'b00, x_r});
        case (dir_use_s)
            2'sb01:  x_step_s = x_ext_s + SPEED_S;
            2'sb11:  x_step_s = x_ext_s - SPEED_S;
            default: x_step_s = x_ext_s;
        endcase

        if (x_step_s < X_MIN_S) begin
            x_sat_s = X_MIN_U;
        end else if (x_step_s > X_MAX_S) begin
            x_sat_s = X_MAX_U;
        end else begin
            x_sat_s = x_step_s[9:0];
        end

        vel_air_s   = vel_r + GRAV_V;
        y_air_s     = y_q_r + 16'(vel_air_s);
        y_jump_s    = y_q_r + 16'(JUMP_V);
        jump_edge_s = op_jump && !jump_prev_r;
    end

    // Next-state logic: round_rst overrides everything, including a same-cycle tick
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_q_s       = y_q_r;
        vel_s       = vel_r;
        smash_cnt_s = smash_cnt_r;
        frz_cnt_s   = frz_cnt_r;
        jump_prev_s = jump_prev_r;
`ifdef PLAYER_AIR_LOCK_EN
        dir_s       = dir_r;
`endif
        if (round_rst) begin
            state_s     = ST_FROZEN;
            x_s         = HOME_U;
            y_q_s       = FLOOR_Q;
            vel_s       = 11'sd0;
            smash_cnt_s = 8'd0;
            frz_cnt_s   = FREEZE_C;
`ifdef PLAYER_AIR_LOCK_EN
            dir_s       = 2'sb00;
`endif
        end else if (frame_tick) begin
            case (state_r)
                ST_GROUND: begin
                    x_s         = x_sat_s;
                    jump_prev_s = op_jump;
                    if (op_jump) begin
                        // take-off tick applies JUMP_VEL without gravity
                        state_s = ST_AIR;
                        vel_s   = JUMP_V;
                        y_q_s   = y_jump_s;
`ifdef PLAYER_AIR_LOCK_EN
                        dir_s   = live_dir_s;
`endif
                    end else begin
                        state_s = ST_GROUND;
                    end
                end
                ST_AIR, ST_SMASH: begin
                    x_s         = x_sat_s;
                    jump_prev_s = op_jump;
                    if (y_air_s >= FLOOR_Q) begin
                        // landing wins over any smash still running
                        state_s     = ST_GROUND;
                        y_q_s       = FLOOR_Q;
                        vel_s       = 11'sd0;
                        smash_cnt_s = 8'd0;
`ifdef PLAYER_AIR_LOCK_EN
                        dir_s       = 2'sb00;
`endif
                    end else begin
                        if (y_air_s < 16'sd0) begin
                            y_q_s = 16'sd0;
                            vel_s = 11'sd0;
                        end else begin
                            y_q_s = y_air_s;
                            vel_s = vel_air_s;
                        end
                        if (state_r == ST_AIR) begin
                            if (jump_edge_s) begin
                                state_s     = ST_SMASH;
                                smash_cnt_s = SMASH_C;
                            end else begin
                                state_s = ST_AIR;
                            end
                        end else if (smash_cnt_r <= 8'd1) begin
                            state_s     = ST_AIR;
                            smash_cnt_s = 8'd0;
                        end else begin
                            smash_cnt_s = smash_cnt_r - 8'd1;
                        end
                    end
                end
                ST_FROZEN: begin
                    if (frz_cnt_r <= 8'd1) begin
                        // key already held at release must not count as a fresh edge
                        state_s     = ST_GROUND;
                        frz_cnt_s   = 8'd0;
                        jump_prev_s = op_jump;
                    end else begin
                        frz_cnt_s = frz_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_s = ST_GROUND;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_GROUND;
            x_r         <= HOME_U;
            y_q_r       <= FLOOR_Q;
            vel_r       <= 11'sd0;
            smash_cnt_r <= 8'd0;
            frz_cnt_r   <= 8'd0;
            jump_prev_r <= 1'b0;
            is_smash_r  <= 1'b0;
            airborne_r  <= 1'b0;
`ifdef PLAYER_AIR_LOCK_EN
            dir_r       <= 2'sb00;
`endif
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_q_r       <= y_q_s;
            vel_r       <= vel_s;
            smash_cnt_r <= smash_cnt_s;
            frz_cnt_r   <= frz_cnt_s;
            jump_prev_r <= jump_prev_s;
            is_smash_r  <= (state_s == ST_SMASH);
            airborne_r  <= (state_s == ST_AIR) || (state_s == ST_SMASH);
`ifdef PLAYER_AIR_LOCK_EN
            dir_r       <= dir_s;
`endif
        end
    end

    assign pos_x    = x_r;
    assign pos_y    = y_q_r[15:6];
    assign is_smash = is_smash_r;
    assign airborne = airborne_r;

endmodule

// File: tb/tb_player_motion.sv
// -----------------------------------------------------------------------------
// tb_player_motion
// Directed bench for player_motion with default parameters. A frame-level
// model (position in 1/64 px, frames left in smash / freeze) predicts the
// outputs and is compared on every falling clock edge; literal expectations
// pin the key numbers of the trajectory, clamping, smash and freeze behaviour.
// -----------------------------------------------------------------------------
module tb_player_motion;

    localparam int HOME    = 36;
    localparam int XMIN    = 0;
    localparam int XMAX    = 90;
    localparam int FLOOR_Q = 176 * 64;
    localparam int SPEED   = 3;
    localparam int JV      = -512;
    localparam int GR      = 24;
    localparam int SLEN    = 8;
    localparam int FLEN    = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       ml = 1'b0;
    logic       mr = 1'b0;
    logic       mj = 1'b0;
    logic       rr = 1'b0;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       is_smash;
    logic       airborne;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    player_motion dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .op_move_left (ml),
        .op_move_right(mr),
        .op_jump      (mj),
        .round_rst    (rr),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .is_smash     (is_smash),
        .airborne     (airborne)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int x;
        int yq;
        int vel;
        bit in_air;
        int smash_left;
        int freeze_left;
        bit key_was;
        int lock_dir;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t n;
        n.x = HOME; n.yq = FLOOR_Q; n.vel = 0; n.in_air = 1'b0;
        n.smash_left = 0; n.freeze_left = 0; n.key_was = 1'b0; n.lock_dir = 0;
        return n;
    endfunction

    // One clock of the frame-level player model
    function automatic mstate_t model_next(mstate_t c, bit tick, bit rst, bit l, bit r, bit j);
        mstate_t n;
        int dir, nx, ny, nv;
        n = c;
        if (rst) begin
            n = model_reset();
            n.freeze_left = FLEN;
            n.key_was = c.key_was;
            return n;
        end
        if (!tick) return n;
        if (c.freeze_left > 0) begin
            n.freeze_left = c.freeze_left - 1;
            if (n.freeze_left == 0) n.key_was = j;
            return n;
        end
        dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
`ifdef PLAYER_AIR_LOCK_EN
        if (c.in_air) dir = c.lock_dir;
`endif
        nx = c.x + SPEED * dir;
        if (nx < XMIN) nx = XMIN;
        if (nx > XMAX) nx = XMAX;
        n.x = nx;
        n.key_was = j;
        if (!c.in_air) begin
            if (j) begin
                n.in_air = 1'b1;
                n.vel = JV;
                n.yq = c.yq + JV;
                n.lock_dir = dir;
            end
        end else begin
            nv = c.vel + GR;
            ny = c.yq + nv;
            if (ny >= FLOOR_Q) begin
                n.yq = FLOOR_Q; n.vel = 0; n.in_air = 1'b0;
                n.smash_left = 0; n.lock_dir = 0;
            end else begin
                if (ny < 0) begin ny = 0; nv = 0; end
                n.yq = ny;
                n.vel = nv;
                if (c.smash_left > 0) n.smash_left = c.smash_left - 1;
                else if (j && !c.key_was) n.smash_left = SLEN;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, frame_tick, rr, ml, mr, mj);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model comparison on every falling edge once out of the first reset
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("model_pos_x", int'(pos_x), m.x);
            check("model_pos_y", int'(pos_y), m.yq / 64);
            check("model_is_smash", int'(is_smash), (m.smash_left > 0) ? 1 : 0);
            check("model_airborne", int'(airborne), m.in_air ? 1 : 0);
        end
    end

    task automatic tick(input bit l, input bit r, input bit j);
        @(negedge clk);
        ml = l; mr = r; mj = j; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic round_reset(input bit with_tick, input bit l, input bit r, input bit j);
        @(negedge clk);
        rr = 1'b1; frame_tick = with_tick; ml = l; mr = r; mj = j;
        @(negedge clk);
        rr = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic wait_land();
        int k;
        k = 0;
        while (airborne && k < 100) begin
            tick(1'b0, 1'b0, 1'b0);
            k++;
        end
        check("land_timeout", int'(airborne), 0);
    endtask

    initial begin
        int cnt;
        #12;
        check("rst_pos_x", int'(pos_x), 36);
        check("rst_pos_y", int'(pos_y), 176);
        check("rst_is_smash", int'(is_smash), 0);
        check("rst_airborne", int'(airborne), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // asynchronous reset in the middle of a jump
        tick(1'b0, 1'b1, 1'b1);
        check("takeoff_x", int'(pos_x), 39);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_x", int'(pos_x), 36);
        check("async_rst_y", int'(pos_y), 176);
        check("async_rst_smash", int'(is_smash), 0);
        check("async_rst_air", int'(airborne), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // jump trajectory
        tick(1'b0, 1'b0, 1'b1);
        check("traj_t1_y", int'(pos_y), 168);
        check("traj_t1_air", int'(airborne), 1);
        tick(1'b0, 1'b0, 1'b0);
        check("traj_t2_y", int'(pos_y), 160);
        repeat (41) tick(1'b0, 1'b0, 1'b0);
        check("traj_t43_y", int'(pos_y), 170);
        check("traj_t43_air", int'(airborne), 1);
        tick(1'b0, 1'b0, 1'b0);
        check("traj_land_y", int'(pos_y), 176);
        check("traj_land_air", int'(airborne), 0);

        // horizontal clamping
        tick(1'b1, 1'b0, 1'b0);
        check("left_1", int'(pos_x), 33);
        tick(1'b1, 1'b0, 1'b0);
        check("left_2", int'(pos_x), 30);
        repeat (18) tick(1'b1, 1'b0, 1'b0);
        check("left_sat", int'(pos_x), 0);
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        check("both_at_0", int'(pos_x), 0);
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        check("right_2", int'(pos_x), 6);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        check("both_at_6", int'(pos_x), 6);
        repeat (30) tick(1'b0, 1'b1, 1'b0);
        check("right_sat", int'(pos_x), 90);

        // smash window on a fresh press
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (is_smash) cnt++;
        end
        check("smash_frames", cnt, 8);
        wait_land();

        // key held from take-off never smashes
        cnt = 0;
        repeat (50) begin
            tick(1'b0, 1'b0, 1'b1);
            if (is_smash) cnt++;
        end
        check("held_no_smash", cnt, 0);
        wait_land();

        // landing inside the smash window
        tick(1'b0, 1'b0, 1'b1);
        repeat (40) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("late_smash_on", int'(is_smash), 1);
        tick(1'b0, 1'b0, 1'b1);
        check("late_smash_y", int'(pos_y), 170);
        tick(1'b0, 1'b0, 1'b1);
        check("late_land_smash", int'(is_smash), 0);
        check("late_land_air", int'(airborne), 0);
        check("late_land_y", int'(pos_y), 176);

        // round reset coincident with a tick while airborne
        tick(1'b1, 1'b0, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        check("pre_rr_x", int'(pos_x), 78);
        check("pre_rr_air", int'(airborne), 1);
        round_reset(1'b1, 1'b1, 1'b0, 1'b1);
        check("rr_x", int'(pos_x), 36);
        check("rr_y", int'(pos_y), 176);
        check("rr_air", int'(airborne), 0);
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check("frozen_air", int'(airborne), 0);
            check("frozen_x", int'(pos_x), 36);
        end
        tick(1'b1, 1'b0, 1'b1);
        check("unfrozen_air", int'(airborne), 1);
        check("unfrozen_y", int'(pos_y), 168);
        check("unfrozen_x", int'(pos_x), 33);
        wait_land();

        // round reset during freeze reloads the counter
        round_reset(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick(1'b0, 1'b0, 1'b1);
        round_reset(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            check("reload_air", int'(airborne), 0);
        end
        tick(1'b0, 1'b0, 1'b1);
        check("reload_jump", int'(airborne), 1);
        wait_land();

        // direction while airborne: latched or live depending on build
        tick(1'b0, 1'b1, 1'b1);
        check("lock_takeoff_x", int'(pos_x), 39);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
`ifdef PLAYER_AIR_LOCK_EN
        check("air_dir_x", int'(pos_x), 48);
`else
        check("air_dir_x", int'(pos_x), 30);
`endif
        wait_land();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
